// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider.
// Holds the 2-bit FSM state encodings, the ready/start level names and the
// common ZeroWord/RstEnable constants used by div_seq and the EX stage.
package div_seq_pkg;

  // Divider FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic        RstEnable         = 1'b1;

endpackage

// File: rtl/div_seq.sv
// Multi-cycle 32-bit restoring divider, signed or unsigned.
// A request is accepted from FREE, runs 32 restoring steps (one quotient bit
// per cycle, MSB first) and presents {remainder, quotient} in END until the
// requester drops start_i. A zero divisor short-cuts through BYZERO with a
// zero result.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   signed_div_i 1 = two's-complement divide, 0 = unsigned
//   opdata1_i    dividend
//   opdata2_i    divisor
//   start_i      divide request, held until ready_o is seen
//   annul_i      cancel the in-flight divide (pipeline flush)
//   result_o     {remainder[31:0], quotient[31:0]}, zero while not ready
//   ready_o      result_o valid
//   busy_o       any state other than FREE
module div_seq
  import div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  div_state_t  state, state_next;
  logic [5:0]  cnt, cnt_next;
  logic [64:0] shreg, shreg_next;
  logic [31:0] divisor, divisor_next;
  logic        neg_quot, neg_quot_next;
  logic        neg_rem, neg_rem_next;
  logic [63:0] result_next;
  logic        ready_next;

  logic [31:0] op1_mag, op2_mag;
  logic [32:0] trial;
  logic [31:0] quot_fix, rem_fix;

  // Shift register layout: [64:33] final remainder, [63:32] partial remainder
  // seen by the trial subtract, [31:0] quotient bits. It starts as
  // {32'b0, dividend, 1'b0} so the first shift presents dividend[31].
  always_comb begin
    op1_mag  = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    op2_mag  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    trial    = {1'b0, shreg[63:32]} - {1'b0, divisor};
    quot_fix = neg_quot ? (~shreg[31:0] + 32'd1) : shreg[31:0];
    rem_fix  = neg_rem ? (~shreg[64:33] + 32'd1) : shreg[64:33];
  end

  // Next-state and datapath update; outputs are registered from these.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    shreg_next    = shreg;
    divisor_next  = divisor;
    neg_quot_next = neg_quot;
    neg_rem_next  = neg_rem;
    ready_next    = ready_o;
    result_next   = result_o;

    case (state)
      DivFree: begin
        ready_next  = DivResultNotReady;
        result_next = {ZeroWord, ZeroWord};
        if (start_i == DivStart && !annul_i) begin
          // Sign corrections are decided now from the original operands.
          neg_quot_next = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_next  = signed_div_i && opdata1_i[31];
          divisor_next  = op2_mag;
          cnt_next      = 6'd0;
          if (opdata2_i == ZeroWord) begin
            state_next = DivByZero;
            shreg_next = 65'd0;
          end else begin
            state_next = DivOn;
            shreg_next = {32'd0, op1_mag, 1'b0};
          end
        end
      end

      DivByZero: begin
        if (annul_i) begin
          state_next = DivFree;
        end else begin
          state_next  = DivEnd;
          ready_next  = DivResultReady;
          result_next = {ZeroWord, ZeroWord};
        end
      end

      DivOn: begin
        // Annul has priority, including over the final cnt==32 step.
        if (annul_i) begin
          state_next  = DivFree;
          cnt_next    = 6'd0;
          shreg_next  = 65'd0;
          ready_next  = DivResultNotReady;
          result_next = {ZeroWord, ZeroWord};
        end else if (cnt == 6'd32) begin
          state_next  = DivEnd;
          cnt_next    = 6'd0;
          ready_next  = DivResultReady;
          result_next = {rem_fix, quot_fix};
        end else begin
          // A borrow out of the 33-bit subtract means the divisor did not fit.
          if (trial[32]) begin
            shreg_next = {shreg[63:0], 1'b0};
          end else begin
            shreg_next = {trial[31:0], shreg[31:0], 1'b1};
          end
          cnt_next = cnt + 6'd1;
        end
      end

      DivEnd: begin
        if (start_i == DivStop) begin
          state_next  = DivFree;
          shreg_next  = 65'd0;
          ready_next  = DivResultNotReady;
          result_next = {ZeroWord, ZeroWord};
        end
      end

      default: begin
        state_next = DivFree;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= DivFree;
      cnt      <= 6'd0;
      shreg    <= 65'd0;
      divisor  <= ZeroWord;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      ready_o  <= DivResultNotReady;
      result_o <= {ZeroWord, ZeroWord};
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      shreg    <= shreg_next;
      divisor  <= divisor_next;
      neg_quot <= neg_quot_next;
      neg_rem  <= neg_rem_next;
      ready_o  <= ready_next;
      result_o <= result_next;
    end
  end

  assign busy_o = (state != DivFree);

endmodule
